// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: serialises ALU (A) and load (B) writebacks
// with starvation-bounded priority and tracks pending writes for decode stalls.
module rf_write_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              WriteReg,
  output logic [ADDR_W-1:0] DstReg,
  output logic [DATA_W-1:0] DstData
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starveCnt;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busyNext;
  logic              grantA;
  logic              grantB;
  logic              anyGrant;
  logic [ADDR_W-1:0] selReg;
  logic [DATA_W-1:0] selData;

  // A normally wins a collision; B wins once it has been blocked LIMIT times in a row.
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (rst) begin
      if (a_valid && b_valid) begin
        if (starveCnt == LIMIT) grantB = 1'b1;
        else                    grantA = 1'b1;
      end else if (a_valid) begin
        grantA = 1'b1;
      end else if (b_valid) begin
        grantB = 1'b1;
      end
    end
  end

  assign a_ready  = grantA;
  assign b_ready  = grantB;
  assign anyGrant = grantA || grantB;
  assign selReg   = grantB ? b_reg  : a_reg;
  assign selData  = grantB ? b_data : a_data;

  // Reservation is applied after the commit clear so a same-cycle re-reserve survives.
  always_comb begin
    busyNext = busy;
    if (WriteReg) busyNext[DstReg] = 1'b0;
    if (rsv_valid && (rsv_reg != '0)) busyNext[rsv_reg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      WriteReg  <= 1'b0;
      DstReg    <= '0;
      DstData   <= '0;
      busy      <= '0;
      starveCnt <= '0;
    end else begin
      WriteReg <= anyGrant && (selReg != '0);
      if (anyGrant) begin
        DstReg  <= selReg;
        DstData <= selData;
      end
      if (!b_valid || grantB)     starveCnt <= '0;
      else if (starveCnt != LIMIT) starveCnt <= starveCnt + 1'b1;
      busy <= busyNext;
    end
  end

  // A write committing this cycle reaches readers via the register-file bypass.
  assign chk_busy1 = (chk_reg1 != '0) && busy[chk_reg1] && !(WriteReg && (DstReg == chk_reg1));
  assign chk_busy2 = (chk_reg2 != '0) && busy[chk_reg2] && !(WriteReg && (DstReg == chk_reg2));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of grants, commits and busy bits.
module tb_rf_write_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int LIMIT  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              a_valid = 1'b0, b_valid = 1'b0, rsv_valid = 1'b0;
  logic [ADDR_W-1:0] a_reg = '0, b_reg = '0, rsv_reg = '0, chk_reg1 = '0, chk_reg2 = '0;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic              a_ready, b_ready, chk_busy1, chk_busy2, WriteReg;
  logic [ADDR_W-1:0] DstReg;
  logic [DATA_W-1:0] DstData;

  int assertCount = 0;
  int failCount   = 0;

  int          mStarve = 0;
  bit          mBusy[16];
  bit          mOutW = 0;
  logic [3:0]  mOutReg = '0;
  logic [15:0] mOutData = '0;
  bit          expA, expB;

  always #10 clk = ~clk;

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit av, input logic [3:0] ar, input logic [15:0] ad,
                               input bit bv, input logic [3:0] br, input logic [15:0] bd,
                               input bit rv, input logic [3:0] rr,
                               input logic [3:0] c1, input logic [3:0] c2);
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    rsv_valid = rv; rsv_reg = rr;
    chk_reg1 = c1; chk_reg2 = c2;
  endtask

  function automatic bit expBusy(input logic [3:0] r);
    return (r != 0) && mBusy[r] && !(mOutW && mOutReg == r);
  endfunction

  // Grant rule: A by default, B alone when only B asks or B has waited LIMIT cycles.
  function automatic void modelGrant();
    expA = 0;
    expB = 0;
    if (rst) begin
      if (a_valid && b_valid) begin
        if (mStarve >= LIMIT) expB = 1;
        else                  expA = 1;
      end else if (a_valid) expA = 1;
      else if (b_valid)     expB = 1;
    end
  endfunction

  function automatic void updateModel();
    bit         commitW;
    logic [3:0] commitR;
    if (!rst) begin
      mStarve = 0;
      foreach (mBusy[i]) mBusy[i] = 0;
      mOutW = 0;
      mOutReg = '0;
      mOutData = '0;
    end else begin
      commitW = mOutW;
      commitR = mOutReg;
      if (expA || expB) begin
        mOutReg  = expB ? b_reg : a_reg;
        mOutData = expB ? b_data : a_data;
        mOutW    = (mOutReg != 0);
      end else begin
        mOutW = 0;
      end
      if (b_valid && !expB) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
      else                  mStarve = 0;
      if (commitW) mBusy[commitR] = 0;
      if (rsv_valid && rsv_reg != 0) mBusy[rsv_reg] = 1;
    end
  endfunction

  // One clock: compare everything at the falling edge, then step the model at the rising edge.
  task automatic advance();
    @(negedge clk);
    modelGrant();
    checkOutput("a_ready", a_ready, expA);
    checkOutput("b_ready", b_ready, expB);
    checkOutput("WriteReg", WriteReg, mOutW);
    if (mOutW) begin
      checkOutput("DstReg", DstReg, mOutReg);
      checkOutput("DstData", DstData, mOutData);
    end
    checkOutput("chk_busy1", chk_busy1, expBusy(chk_reg1));
    checkOutput("chk_busy2", chk_busy2, expBusy(chk_reg2));
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    foreach (mBusy[i]) mBusy[i] = 0;

    // Reset held with both sources requesting
    rst = 1'b0;
    applyStimulus(1, 4'd1, 16'h1111, 1, 4'd2, 16'h2222, 0, 4'd0, 4'd0, 4'd0);
    advance();
    checkOutput("rst_a_ready", a_ready, 0);
    checkOutput("rst_b_ready", b_ready, 0);
    advance();
    rst = 1'b1;
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
    checkOutput("post_rst_WriteReg", WriteReg, 0);
    for (int r = 0; r < 16; r++) begin
      chk_reg1 = 4'(r);
      chk_reg2 = 4'(15 - r);
      advance();
    end

    // Single A write appears exactly one cycle later
    applyStimulus(1, 4'd5, 16'hBEEF, 0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
    #1 checkOutput("single_a_ready", a_ready, 1);
    advance();
    a_valid = 0;
    checkOutput("single_WriteReg", WriteReg, 1);
    checkOutput("single_DstReg", DstReg, 5);
    checkOutput("single_DstData", DstData, 16'hBEEF);
    advance();
    checkOutput("single_pulse_end", WriteReg, 0);

    // Starvation: both sources always valid -> A,A,A,B,A,A,A,B
    applyStimulus(1, 4'd1, 16'hA000, 1, 4'd2, 16'hB000, 0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      a_data = 16'hA000 + 16'(i);
      b_data = 16'hB000 + 16'(i);
      #1 checkOutput("starve_b_ready", b_ready, (i % 4) == 3);
      advance();
    end
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
    advance();

    // Scoreboard: reserve reg 7, B writes it three cycles later
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd7, 4'd7, 4'd7);
    advance();
    rsv_valid = 0;
    #1 checkOutput("sb_busy_after_rsv", chk_busy1, 1);
    advance();
    advance();
    b_valid = 1; b_reg = 4'd7; b_data = 16'h7777;
    advance();
    b_valid = 0;
    checkOutput("sb_commit_WriteReg", WriteReg, 1);
    checkOutput("sb_busy_on_commit", chk_busy1, 0);
    advance();
    checkOutput("sb_busy_after", chk_busy1, 0);

    // Reg 0 accepted silently, then set/clear race on reg 3
    applyStimulus(1, 4'd0, 16'h0F0F, 0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd0);
    #1 checkOutput("r0_a_ready", a_ready, 1);
    advance();
    checkOutput("r0_no_write", WriteReg, 0);
    applyStimulus(1, 4'd3, 16'h3333, 0, 4'd0, 16'h0, 0, 4'd0, 4'd3, 4'd0);
    advance();
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd3, 4'd3, 4'd0);
    checkOutput("race_commit", WriteReg, 1);
    advance();
    rsv_valid = 0;
    checkOutput("race_set_wins", chk_busy1, 1);
    advance();

    // Reset in the cycle after a handshake cancels the write and busy bits
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd9, 4'd9, 4'd0);
    advance();
    applyStimulus(1, 4'd9, 16'h9999, 0, 4'd0, 16'h0, 0, 4'd0, 4'd9, 4'd0);
    advance();
    a_valid = 0;
    rst = 1'b0;
    advance();
    rst = 1'b1;
    checkOutput("midrst_WriteReg", WriteReg, 0);
    checkOutput("midrst_busy9", chk_busy1, 0);
    advance();

    // Random traffic: sources hold each request until the model says it was granted
    applyStimulus(0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 600; i++) begin
      if (!a_valid && ($urandom % 3) != 0) begin
        a_valid = 1; a_reg = 4'($urandom); a_data = 16'($urandom);
      end
      if (!b_valid && ($urandom % 2) != 0) begin
        b_valid = 1; b_reg = 4'($urandom); b_data = 16'($urandom);
      end
      rsv_valid = ($urandom % 3) == 0;
      rsv_reg   = 4'($urandom);
      chk_reg1  = 4'($urandom);
      chk_reg2  = 4'($urandom);
      rst       = ($urandom % 64) != 0;
      advance();
      if (expA) a_valid = 0;
      if (expB) b_valid = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
